// File: rtl/ahb_xfer_launcher.sv
// AHB-Lite INCR burst master launched by single-cycle write/read request pulses.
// Address and data phases are pipelined; registered bus controls, strobe outputs follow the data phase.
module ahb_xfer_launcher #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 4
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          wr_req_pulse,
  input  logic          rd_req_pulse,
  input  logic [AW-1:0] xfer_addr,
  input  logic [2:0]    xfer_size,
  input  logic [LW-1:0] xfer_len,
  input  logic [DW-1:0] wdata,
  output logic          wdata_pop,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic          done_pulse,
  output logic          err,
  output logic          busy,
  output logic          overrun,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [2:0]    HBURST,
  output logic [DW-1:0] HWDATA,
  input  logic [DW-1:0] HRDATA,
  input  logic          HREADY,
  input  logic          HRESP
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR2 = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;

  localparam logic [2:0]  C_MAX_SIZE = (DW == 64) ? 3'd3 : 3'd2;
  localparam logic [LW:0] C_ONE      = (LW+1)'(1);
  localparam logic [LW:0] C_TWO      = (LW+1)'(2);

  logic [2:0]    r_state;
  logic [AW-1:0] r_haddr;
  logic [1:0]    r_htrans;
  logic          r_hwrite;
  logic [2:0]    r_hsize;
  logic [2:0]    r_hburst;
  logic [LW:0]   r_rem;
  logic          r_err;
  logic          r_overrun;

  logic          w_req;
  logic          w_accept;
  logic          w_drop;
  logic          w_size_ok;
  logic [AW-1:0] w_incr;
  logic [AW-1:0] w_next_addr;
  logic          w_cross;
  logic [1:0]    w_next_trans;
  logic          w_beat_ok;

  assign w_req        = wr_req_pulse | rd_req_pulse;
  assign w_accept     = (r_state == S_IDLE) & w_req;
  assign w_drop       = ((r_state != S_IDLE) & w_req) |
                        ((r_state == S_IDLE) & wr_req_pulse & rd_req_pulse);
  assign w_size_ok    = (xfer_size <= C_MAX_SIZE);
  assign w_incr       = {{(AW-1){1'b0}}, 1'b1} << r_hsize;
  assign w_next_addr  = r_haddr + w_incr;
  // A burst may not cross a 1KB boundary, so the crossing beat restarts as NONSEQ.
  assign w_cross      = (w_next_addr[AW-1:10] != r_haddr[AW-1:10]);
  assign w_next_trans = w_cross ? TR_NONSEQ : TR_SEQ;
  assign w_beat_ok    = (r_state == S_DATA) & HREADY & ~HRESP;

  // r_rem counts data phases still owed; in DATA a further address is pending while r_rem > 2.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state   <= S_IDLE;
      r_haddr   <= {AW{1'b0}};
      r_htrans  <= TR_IDLE;
      r_hwrite  <= 1'b0;
      r_hsize   <= 3'd0;
      r_hburst  <= BURST_SINGLE;
      r_rem     <= {(LW+1){1'b0}};
      r_err     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_drop;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_hwrite <= wr_req_pulse;
            r_hsize  <= xfer_size;
            r_haddr  <= xfer_addr;
            r_hburst <= (xfer_len == {LW{1'b0}}) ? BURST_SINGLE : BURST_INCR;
            r_rem    <= {1'b0, xfer_len} + C_ONE;
            r_err    <= 1'b0;
            if (w_size_ok) begin
              r_htrans <= TR_NONSEQ;
              r_state  <= S_ADDR;
            end else begin
              r_htrans <= TR_IDLE;
              r_state  <= S_ERR2;
            end
          end else begin
            r_htrans <= TR_IDLE;
          end
        end
        S_ADDR: begin
          if (HREADY) begin
            r_state <= S_DATA;
            if (r_rem > C_ONE) begin
              r_haddr  <= w_next_addr;
              r_htrans <= w_next_trans;
            end else begin
              r_htrans <= TR_IDLE;
            end
          end else begin
            r_state <= S_ADDR;
          end
        end
        S_DATA: begin
          if (HRESP && !HREADY) begin
            r_htrans <= TR_IDLE;
            r_state  <= S_ERR2;
          end else if (HRESP && HREADY) begin
            r_htrans <= TR_IDLE;
            r_err    <= 1'b1;
            r_state  <= S_DONE;
          end else if (HREADY) begin
            r_rem <= r_rem - C_ONE;
            if (r_rem == C_ONE) begin
              r_htrans <= TR_IDLE;
              r_state  <= S_DONE;
            end else if (r_rem > C_TWO) begin
              r_haddr  <= w_next_addr;
              r_htrans <= w_next_trans;
            end else begin
              r_htrans <= TR_IDLE;
            end
          end else begin
            r_state <= S_DATA;
          end
        end
        S_ERR2: begin
          r_htrans <= TR_IDLE;
          if (HREADY) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_ERR2;
          end
        end
        S_DONE: begin
          r_htrans <= TR_IDLE;
          r_state  <= S_IDLE;
        end
        default: begin
          r_htrans <= TR_IDLE;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done_pulse  = (r_state == S_DONE);
  assign err         = r_err;
  assign overrun     = r_overrun;
  assign wdata_pop   = w_beat_ok & r_hwrite;
  assign rdata_valid = w_beat_ok & ~r_hwrite;
  assign rdata       = rdata_valid ? HRDATA : {DW{1'b0}};
  assign HWDATA      = ((r_state == S_DATA) && r_hwrite) ? wdata : {DW{1'b0}};
  assign HADDR       = r_haddr;
  assign HTRANS      = r_htrans;
  assign HWRITE      = r_hwrite;
  assign HSIZE       = r_hsize;
  assign HBURST      = r_hburst;

endmodule

// File: tb/tb_ahb_xfer_launcher.sv
// Directed bench for ahb_xfer_launcher: cycle-by-cycle expected bus and status values.
module tb_ahb_xfer_launcher;

  logic        HCLK;
  logic        HRESETn;
  logic        wr_req_pulse;
  logic        rd_req_pulse;
  logic [31:0] xfer_addr;
  logic [2:0]  xfer_size;
  logic [3:0]  xfer_len;
  logic [31:0] wdata;
  logic        wdata_pop;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done_pulse;
  logic        err;
  logic        busy;
  logic        overrun;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int n_pass = 0;
  int n_total = 0;
  int widx = 0;
  int rv_cnt = 0;
  int rv_base;

  ahb_xfer_launcher #(.AW(32), .DW(32), .LW(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .wr_req_pulse(wr_req_pulse), .rd_req_pulse(rd_req_pulse),
    .xfer_addr(xfer_addr), .xfer_size(xfer_size), .xfer_len(xfer_len),
    .wdata(wdata), .wdata_pop(wdata_pop), .rdata(rdata), .rdata_valid(rdata_valid),
    .done_pulse(done_pulse), .err(err), .busy(busy), .overrun(overrun),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Upstream write buffer: each pop advances to the next word.
  assign wdata = 32'hD000_0000 + widx;
  always @(posedge HCLK) begin
    if (wdata_pop) widx <= widx + 1;
    if (rdata_valid) rv_cnt <= rv_cnt + 1;
  end

  task automatic tick();
    @(posedge HCLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    HRESETn = 1'b0; wr_req_pulse = 1'b0; rd_req_pulse = 1'b0;
    xfer_addr = 32'h0; xfer_size = 3'd2; xfer_len = 4'd0;
    HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
    tick(); tick(); #1;
    chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done_pulse}, 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_hburst", {29'd0, HBURST}, 32'd0);
    tick(); HRESETn = 1'b1;

    // Read single at 0x100
    tick(); rd_req_pulse = 1'b1; xfer_addr = 32'h100; xfer_size = 3'd2; xfer_len = 4'd0; #1;
    chk("rs_idle_busy", {31'd0, busy}, 32'd0);
    tick(); rd_req_pulse = 1'b0; #1;
    chk("rs_t1_htrans", {30'd0, HTRANS}, 32'd2);
    chk("rs_t1_haddr", HADDR, 32'h100);
    chk("rs_t1_hburst", {29'd0, HBURST}, 32'd0);
    chk("rs_t1_hwrite", {31'd0, HWRITE}, 32'd0);
    chk("rs_t1_busy", {31'd0, busy}, 32'd1);
    tick(); HRDATA = 32'hCAFE_0001; #1;
    chk("rs_t2_valid", {31'd0, rdata_valid}, 32'd1);
    chk("rs_t2_rdata", rdata, 32'hCAFE_0001);
    chk("rs_t2_htrans", {30'd0, HTRANS}, 32'd0);
    tick(); #1;
    chk("rs_t3_done", {31'd0, done_pulse}, 32'd1);
    chk("rs_t3_err", {31'd0, err}, 32'd0);
    chk("rs_t3_busy", {31'd0, busy}, 32'd1);
    tick(); #1;
    chk("rs_t4_busy", {31'd0, busy}, 32'd0);
    chk("rs_t4_done", {31'd0, done_pulse}, 32'd0);

    // Write INCR4 at 0x200, one wait state on beat 2
    tick(); wr_req_pulse = 1'b1; xfer_addr = 32'h200; xfer_len = 4'd3; #1;
    tick(); wr_req_pulse = 1'b0; #1;
    chk("wi_t1_htrans", {30'd0, HTRANS}, 32'd2);
    chk("wi_t1_haddr", HADDR, 32'h200);
    chk("wi_t1_hburst", {29'd0, HBURST}, 32'd1);
    chk("wi_t1_hwrite", {31'd0, HWRITE}, 32'd1);
    tick(); #1;
    chk("wi_t2_htrans", {30'd0, HTRANS}, 32'd3);
    chk("wi_t2_haddr", HADDR, 32'h204);
    chk("wi_t2_hwdata", HWDATA, 32'hD000_0000);
    chk("wi_t2_pop", {31'd0, wdata_pop}, 32'd1);
    tick(); HREADY = 1'b0; #1;
    chk("wi_t3_haddr", HADDR, 32'h208);
    chk("wi_t3_hwdata", HWDATA, 32'hD000_0001);
    chk("wi_t3_pop", {31'd0, wdata_pop}, 32'd0);
    tick(); HREADY = 1'b1; #1;
    chk("wi_t4_haddr_held", HADDR, 32'h208);
    chk("wi_t4_htrans", {30'd0, HTRANS}, 32'd3);
    chk("wi_t4_hwdata", HWDATA, 32'hD000_0001);
    tick(); #1;
    chk("wi_t5_haddr", HADDR, 32'h20C);
    chk("wi_t5_hwdata", HWDATA, 32'hD000_0002);
    tick(); #1;
    chk("wi_t6_htrans", {30'd0, HTRANS}, 32'd0);
    chk("wi_t6_hwdata", HWDATA, 32'hD000_0003);
    chk("wi_t6_done", {31'd0, done_pulse}, 32'd0);
    tick(); #1;
    chk("wi_t7_done", {31'd0, done_pulse}, 32'd1);
    chk("wi_pops", widx, 32'd4);

    // Read across a 1KB boundary
    tick(); rd_req_pulse = 1'b1; xfer_addr = 32'h3F8; xfer_len = 4'd3; #1;
    tick(); rd_req_pulse = 1'b0; #1;
    chk("kb_b0", {HADDR[29:0], HTRANS}, {30'h3F8, 2'd2});
    tick(); #1;
    chk("kb_b1", {HADDR[29:0], HTRANS}, {30'h3FC, 2'd3});
    tick(); #1;
    chk("kb_b2", {HADDR[29:0], HTRANS}, {30'h400, 2'd2});
    tick(); #1;
    chk("kb_b3", {HADDR[29:0], HTRANS}, {30'h404, 2'd3});
    tick(); #1;
    chk("kb_t5_htrans", {30'd0, HTRANS}, 32'd0);
    tick(); #1;
    chk("kb_t6_done", {31'd0, done_pulse}, 32'd1);

    // Error on beat 2 of a 4-beat read
    tick(); rd_req_pulse = 1'b1; xfer_addr = 32'h300; xfer_len = 4'd3; #1;
    rv_base = rv_cnt;
    tick(); rd_req_pulse = 1'b0; #1;
    chk("er_t1_htrans", {30'd0, HTRANS}, 32'd2);
    tick(); HRDATA = 32'h0000_0011; #1;
    chk("er_t2_valid", {31'd0, rdata_valid}, 32'd1);
    tick(); HREADY = 1'b0; HRESP = 1'b1; #1;
    chk("er_t3_htrans", {30'd0, HTRANS}, 32'd3);
    chk("er_t3_haddr", HADDR, 32'h308);
    chk("er_t3_valid", {31'd0, rdata_valid}, 32'd0);
    tick(); HREADY = 1'b1; HRESP = 1'b1; #1;
    chk("er_t4_htrans", {30'd0, HTRANS}, 32'd0);
    chk("er_t4_valid", {31'd0, rdata_valid}, 32'd0);
    tick(); HRESP = 1'b0; #1;
    chk("er_t5_done", {31'd0, done_pulse}, 32'd1);
    chk("er_t5_err", {31'd0, err}, 32'd1);
    chk("er_t5_htrans", {30'd0, HTRANS}, 32'd0);
    tick(); #1;
    chk("er_t6_busy", {31'd0, busy}, 32'd0);
    chk("er_t6_err_hold", {31'd0, err}, 32'd1);
    chk("er_t6_htrans", {30'd0, HTRANS}, 32'd0);
    chk("er_rv_count", rv_cnt - rv_base, 32'd1);

    // Collision: both pulses, then a read while busy, then one in DONE
    tick(); wr_req_pulse = 1'b1; rd_req_pulse = 1'b1; xfer_addr = 32'h40; xfer_len = 4'd0; #1;
    tick(); wr_req_pulse = 1'b0; rd_req_pulse = 1'b1; #1;
    chk("co_t1_overrun", {31'd0, overrun}, 32'd1);
    chk("co_t1_hwrite", {31'd0, HWRITE}, 32'd1);
    chk("co_t1_bus", {HADDR[29:0], HTRANS}, {30'h40, 2'd2});
    chk("co_t1_err_clr", {31'd0, err}, 32'd0);
    tick(); rd_req_pulse = 1'b0; #1;
    chk("co_t2_overrun", {31'd0, overrun}, 32'd1);
    chk("co_t2_pop", {31'd0, wdata_pop}, 32'd1);
    chk("co_t2_hwdata", HWDATA, 32'hD000_0004);
    tick(); rd_req_pulse = 1'b1; #1;
    chk("co_t3_done", {31'd0, done_pulse}, 32'd1);
    chk("co_t3_overrun", {31'd0, overrun}, 32'd0);
    tick(); rd_req_pulse = 1'b0; #1;
    chk("co_t4_overrun", {31'd0, overrun}, 32'd1);
    chk("co_t4_busy", {31'd0, busy}, 32'd0);
    chk("co_t4_htrans", {30'd0, HTRANS}, 32'd0);
    tick(); #1;
    chk("co_t5_htrans", {30'd0, HTRANS}, 32'd0);
    chk("co_t5_overrun", {31'd0, overrun}, 32'd0);

    // Unsupported size: no bus access, error completion
    tick(); rd_req_pulse = 1'b1; xfer_addr = 32'h80; xfer_size = 3'd3; xfer_len = 4'd0; #1;
    tick(); rd_req_pulse = 1'b0; xfer_size = 3'd2; #1;
    chk("us_t1_htrans", {30'd0, HTRANS}, 32'd0);
    chk("us_t1_busy", {31'd0, busy}, 32'd1);
    tick(); #1;
    chk("us_t2_done", {31'd0, done_pulse}, 32'd1);
    chk("us_t2_err", {31'd0, err}, 32'd1);

    // Reset mid-burst, then a normal single write
    tick(); rd_req_pulse = 1'b1; xfer_addr = 32'h500; xfer_len = 4'd3; #1;
    tick(); rd_req_pulse = 1'b0; #1;
    tick(); #1;
    chk("mr_t2_haddr", HADDR, 32'h504);
    tick(); HRESETn = 1'b0; #1;
    tick(); HRESETn = 1'b1; #1;
    chk("mr_t4_htrans", {30'd0, HTRANS}, 32'd0);
    chk("mr_t4_busy", {31'd0, busy}, 32'd0);
    chk("mr_t4_done", {31'd0, done_pulse}, 32'd0);
    chk("mr_t4_err", {31'd0, err}, 32'd0);
    tick(); #1;
    chk("mr_t5_done", {31'd0, done_pulse}, 32'd0);
    tick(); wr_req_pulse = 1'b1; xfer_addr = 32'h600; xfer_len = 4'd0; #1;
    tick(); wr_req_pulse = 1'b0; #1;
    chk("mr_n1_bus", {HADDR[29:0], HTRANS}, {30'h600, 2'd2});
    tick(); #1;
    chk("mr_n2_hwdata", HWDATA, 32'hD000_0005);
    chk("mr_n2_pop", {31'd0, wdata_pop}, 32'd1);
    tick(); #1;
    chk("mr_n3_done", {31'd0, done_pulse}, 32'd1);
    chk("mr_n3_err", {31'd0, err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
